// File: rtl/rtc_char_source_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_char_source_pkg                                                  |
// | Shared mode encodings, ASCII constants and BCD helpers for the RTC.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rtc_char_source_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2,
    MODE_SET_SS = 2'd3
  } mode_e;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  localparam logic [3:0] BCD_MS_TENS_MAX  = 4'd5;
  localparam logic [3:0] BCD_UNITS_MAX    = 4'd9;
  localparam logic [3:0] BCD_HR_TENS_MAX  = 4'd2;
  localparam logic [3:0] BCD_HR_UNITS_MAX = 4'd3;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  function automatic logic bcd_at_max(input bcd2_t v, input logic [3:0] tens_max,
                                      input logic [3:0] units_max);
    return (v.tens == tens_max) && (v.units == units_max);
  endfunction

  // Wraps to 00 at the given decimal limit, otherwise a plain BCD +1.
  function automatic bcd2_t bcd_inc(input bcd2_t v, input logic [3:0] tens_max,
                                    input logic [3:0] units_max);
    bcd2_t r;
    if (bcd_at_max(v, tens_max, units_max)) begin
      r = '0;
    end else if (v.units == BCD_UNITS_MAX) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = v.tens;
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_ascii(input logic [3:0] d);
    return ASC_ZERO + {4'd0, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_char_source_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce                                                         |
// | 2-FF synchronizer, stability counter and one-cycle press pulse.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module btn_debounce
  import rtc_char_source_pkg::*;
#(
  parameter int DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] c_LAST = CW'(DEBOUNCE - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // The DEBOUNCE-th consecutive differing sample flips the accepted level.
  assign w_accept = (r_sync2 != r_level) && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_press <= w_accept & r_sync2;
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/rtc_char_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rtc_char_source                                                      |
// | BCD time-of-day with button setting and a 2x16 ASCII read port.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rtc_char_source
  import rtc_char_source_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       rd_line,
  input  logic [3:0] rd_col,
  output logic [7:0] rd_char,
  output logic       sec_strobe,
  output logic [1:0] mode
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] c_PRESC_LAST = PW'(TICK_DIV - 1);

  mode_e         r_mode;
  mode_e         w_mode_nxt;
  logic [PW-1:0] r_presc;
  bcd2_t         r_hh;
  bcd2_t         r_mm;
  bcd2_t         r_ss;
  logic          r_strobe;
  logic [7:0]    r_rd_char;

  logic       w_mode_press;
  logic       w_inc_press;
  logic       w_inc_set;
  logic       w_tick;
  logic       w_ss_max;
  logic       w_mm_max;
  logic       w_run;
  logic [7:0] w_field_ltr;
  logic [7:0] w_char;

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_db (
    .clk    (clk),
    .rst    (reset),
    .i_btn  (mode_btn),
    .o_press(w_mode_press)
  );

  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc_db (
    .clk    (clk),
    .rst    (reset),
    .i_btn  (inc_btn),
    .o_press(w_inc_press)
  );

  assign w_run     = (r_mode == MODE_RUN);
  assign w_tick    = w_run && (r_presc == c_PRESC_LAST);
  assign w_inc_set = w_inc_press && !w_mode_press && !w_run;
  assign w_ss_max  = bcd_at_max(r_ss, BCD_MS_TENS_MAX, BCD_UNITS_MAX);
  assign w_mm_max  = bcd_at_max(r_mm, BCD_MS_TENS_MAX, BCD_UNITS_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= MODE_RUN;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_mode_press) begin
      case (r_mode)
        MODE_RUN:    w_mode_nxt = MODE_SET_HH;
        MODE_SET_HH: w_mode_nxt = MODE_SET_MM;
        MODE_SET_MM: w_mode_nxt = MODE_SET_SS;
        MODE_SET_SS: w_mode_nxt = MODE_RUN;
      endcase
    end
  end

  // Prescaler sits at 0 outside RUN so the first tick after setting is a full period away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc  <= '0;
      r_strobe <= 1'b0;
    end else begin
      if (!w_run || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_strobe <= w_tick;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hh <= '0;
      r_mm <= '0;
      r_ss <= '0;
    end else if (w_tick) begin
      r_ss <= bcd_inc(r_ss, BCD_MS_TENS_MAX, BCD_UNITS_MAX);
      if (w_ss_max) begin
        r_mm <= bcd_inc(r_mm, BCD_MS_TENS_MAX, BCD_UNITS_MAX);
        if (w_mm_max) begin
          r_hh <= bcd_inc(r_hh, BCD_HR_TENS_MAX, BCD_HR_UNITS_MAX);
        end
      end
    end else if (w_inc_set) begin
      case (r_mode)
        MODE_SET_HH: r_hh <= bcd_inc(r_hh, BCD_HR_TENS_MAX, BCD_HR_UNITS_MAX);
        MODE_SET_MM: r_mm <= bcd_inc(r_mm, BCD_MS_TENS_MAX, BCD_UNITS_MAX);
        MODE_SET_SS: r_ss <= bcd_inc(r_ss, BCD_MS_TENS_MAX, BCD_UNITS_MAX);
        default:     r_hh <= r_hh;
      endcase
    end
  end

  always_comb begin
    w_field_ltr = ASC_SPACE;
    case (r_mode)
      MODE_SET_HH: w_field_ltr = "H";
      MODE_SET_MM: w_field_ltr = "M";
      MODE_SET_SS: w_field_ltr = "S";
      default:     w_field_ltr = ASC_SPACE;
    endcase
  end

  always_comb begin
    w_char = ASC_SPACE;
    if (!rd_line) begin
      case (rd_col)
        4'd0:    w_char = "T";
        4'd1:    w_char = "I";
        4'd2:    w_char = "M";
        4'd3:    w_char = "E";
        4'd5:    w_char = bcd_ascii(r_hh.tens);
        4'd6:    w_char = bcd_ascii(r_hh.units);
        4'd7:    w_char = ASC_COLON;
        4'd8:    w_char = bcd_ascii(r_mm.tens);
        4'd9:    w_char = bcd_ascii(r_mm.units);
        4'd10:   w_char = ASC_COLON;
        4'd11:   w_char = bcd_ascii(r_ss.tens);
        4'd12:   w_char = bcd_ascii(r_ss.units);
        default: w_char = ASC_SPACE;
      endcase
    end else begin
      case (rd_col)
        4'd0:    w_char = "M";
        4'd1:    w_char = "O";
        4'd2:    w_char = "D";
        4'd3:    w_char = "E";
        4'd4:    w_char = ASC_COLON;
        4'd5:    w_char = w_run ? "R" : "S";
        4'd6:    w_char = w_run ? "U" : "E";
        4'd7:    w_char = w_run ? "N" : "T";
        4'd9:    w_char = w_field_ltr;
        4'd10:   w_char = w_field_ltr;
        default: w_char = ASC_SPACE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_char <= ASC_SPACE;
    end else begin
      r_rd_char <= w_char;
    end
  end

  assign rd_char    = r_rd_char;
  assign sec_strobe = r_strobe;
  assign mode       = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_rtc_char_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rtc_char_source                                                   |
// | Directed bench with a time model and a read-port scoreboard.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rtc_char_source;

  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 2;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       mode_btn = 1'b0;
  logic       inc_btn  = 1'b0;
  logic       rd_line  = 1'b0;
  logic [3:0] rd_col   = 4'd0;
  logic [7:0] rd_char;
  logic       sec_strobe;
  logic [1:0] mode;

  always #5 clk = ~clk;

  rtc_char_source #(.TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_btn  (mode_btn),
    .inc_btn   (inc_btn),
    .rd_line   (rd_line),
    .rd_col    (rd_col),
    .rd_char   (rd_char),
    .sec_strobe(sec_strobe),
    .mode      (mode)
  );

  int n_chk = 0;
  int n_fail = 0;
  int nstb = 0;
  int m_hh = 0, m_mm = 0, m_ss = 0;
  int exp_mode = 0;
  logic [7:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic adv_sec();
    m_ss = m_ss + 1;
    if (m_ss == 60) begin
      m_ss = 0;
      m_mm = m_mm + 1;
      if (m_mm == 60) begin
        m_mm = 0;
        m_hh = (m_hh + 1) % 24;
      end
    end
  endtask

  // Every clock advance goes through here so the model tracks each strobe.
  task automatic step();
    @(posedge clk);
    #1;
    if (sec_strobe === 1'b1) begin
      nstb++;
      adv_sec();
    end
  endtask

  function automatic string line0();
    return $sformatf("TIME %02d:%02d:%02d   ", m_hh, m_mm, m_ss);
  endfunction

  function automatic string line1();
    case (exp_mode)
      1:       return "MODE:SET HH     ";
      2:       return "MODE:SET MM     ";
      3:       return "MODE:SET SS     ";
      default: return "MODE:RUN        ";
    endcase
  endfunction

  task automatic rd(input logic ln, input int col, input string tag);
    string s;
    logic [7:0] e;
    logic [7:0] got;
    s = ln ? line1() : line0();
    rd_line = ln;
    rd_col  = 4'(col);
    sb.push_back(s[col]);
    step();
    got = rd_char;
    e = sb.pop_front();
    chk($sformatf("%s_L%0d_C%0d", tag, ln, col), {24'd0, got}, {24'd0, e});
  endtask

  task automatic rd_lines(input string tag);
    for (int c = 0; c < 16; c++) rd(1'b0, c, tag);
    for (int c = 0; c < 16; c++) rd(1'b1, c, tag);
  endtask

  task automatic rd_time(input string tag);
    rd(1'b0, 5, tag); rd(1'b0, 6, tag); rd(1'b0, 8, tag);
    rd(1'b0, 9, tag); rd(1'b0, 11, tag); rd(1'b0, 12, tag);
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    repeat (6) step();
    mode_btn = 1'b0;
    repeat (6) step();
    exp_mode = (exp_mode + 1) % 4;
    chk("mode_after_press", {30'd0, mode}, exp_mode);
  endtask

  task automatic press_inc();
    inc_btn = 1'b1;
    repeat (6) step();
    inc_btn = 1'b0;
    repeat (6) step();
    case (exp_mode)
      1: m_hh = (m_hh + 1) % 24;
      2: m_mm = (m_mm + 1) % 60;
      3: m_ss = (m_ss + 1) % 60;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    m_hh = 0; m_mm = 0; m_ss = 0;
    exp_mode = 0;
    sb.delete();
    chk("rst_rd_char", {24'd0, rd_char}, 32'h20);
    chk("rst_strobe", {31'd0, sec_strobe}, 0);
    chk("rst_mode", {30'd0, mode}, 0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int cnt;
    mode_btn = 1'b0;
    inc_btn  = 1'b0;

    // Reset values, then the power-up display contents.
    do_reset();
    nstb = 0;
    rd_lines("boot");

    // 240 cycles of RUN from reset release must yield exactly 60 strobes and 00:01:00.
    cnt = 32;
    while (cnt < 240) begin
      step();
      cnt++;
    end
    chk("strobes_240", nstb, 60);
    rd(1'b0, 9, "min1"); rd(1'b0, 11, "min1"); rd(1'b0, 12, "min1"); rd(1'b0, 8, "min1");

    // SET_HH: a long hold counts once, then 23 presses wrap hh back to 00 without ticks.
    do_reset();
    press_mode();
    n0 = nstb;
    inc_btn = 1'b1;
    repeat (50) step();
    inc_btn = 1'b0;
    repeat (6) step();
    m_hh = (m_hh + 1) % 24;
    rd(1'b0, 5, "hold"); rd(1'b0, 6, "hold"); rd(1'b0, 8, "hold"); rd(1'b0, 9, "hold");
    repeat (23) press_inc();
    rd(1'b0, 5, "hhwrap"); rd(1'b0, 6, "hhwrap");
    chk("no_tick_in_set", nstb - n0, 0);

    // Preload 23:59:59, then return to RUN and expect a single rollover to 00:00:00.
    repeat (23) press_inc();
    press_mode();
    while (m_mm != 59) press_inc();
    rd(1'b1, 9, "setmm"); rd(1'b1, 10, "setmm");
    press_mode();
    while (m_ss != 59) press_inc();
    rd_lines("preload");
    n0 = nstb;
    press_mode();
    chk("rollover_strobes", nstb - n0, 1);
    rd_time("rollover");

    // A one-cycle glitch is filtered; a four-cycle press is accepted.
    do_reset();
    mode_btn = 1'b1;
    step();
    mode_btn = 1'b0;
    repeat (8) step();
    chk("glitch_mode", {30'd0, mode}, 0);
    mode_btn = 1'b1;
    repeat (4) step();
    mode_btn = 1'b0;
    repeat (8) step();
    exp_mode = 1;
    chk("long_press_mode", {30'd0, mode}, 1);

    // Simultaneous mode+inc: mode advances and the increment is dropped.
    mode_btn = 1'b1;
    inc_btn  = 1'b1;
    repeat (6) step();
    mode_btn = 1'b0;
    inc_btn  = 1'b0;
    repeat (6) step();
    exp_mode = 2;
    chk("both_press_mode", {30'd0, mode}, 2);
    rd_time("both_press");

    // Build 12:34:xx, checking that inc in RUN is ignored along the way.
    press_mode();
    while (m_ss != 50) press_inc();
    press_mode();
    press_inc();
    rd_time("run_inc");
    press_mode();
    while (m_hh != 12) press_inc();
    press_mode();
    while (m_mm != 34) press_inc();
    rd_lines("pre_reset");

    // Asynchronous reset lands between edges and must clear outputs at once.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rd_char", {24'd0, rd_char}, 32'h20);
    chk("async_strobe", {31'd0, sec_strobe}, 0);
    chk("async_mode", {30'd0, mode}, 0);
    step();
    reset = 1'b0;
    m_hh = 0; m_mm = 0; m_ss = 0;
    exp_mode = 0;
    sb.delete();
    rd_lines("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
